tmr_fault_monitor: RTL and testbench
====================================

Name: tmr_fault_monitor

Overview:
- Sits directly downstream of the three redundant NFC copies, alongside the TMR voter, and consumes the same three 27-bit copy output words.
- Each cycle it classifies which copy disagrees with the other two.
- It runs a per-copy health state machine (OK/SUSPECT/FAILED) and requests a reset of a copy that fails persistently.
- It gives the top level a sticky health summary, beyond the voter's single-cycle error bit.

Parameters:
- WIDTH, 27, width of each copy word.
- FAIL_TH, 8, disagree cycles counted in SUSPECT before a copy is declared FAILED (range 1..255).
- CLEAN_TH, 16, consecutive clean cycles in SUSPECT before returning to OK (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  monitoring enable; when 0, comparisons are ignored and state/counters hold.
- clear  in  1  one-cycle pulse: return all copies to OK and clear all counters and sticky flags.
- data_A / data_B / data_C  in  WIDTH each  copy output words, same packing as the voter inputs.
- copy_state  out  6  2 bits per copy, [1:0]=A, [3:2]=B, [5:4]=C; encoding 00 OK, 01 SUSPECT, 10 FAILED.
- copy_rst_req  out  3  one-cycle pulse per copy on entry to FAILED; bit0=A.
- fault_any  out  1  high while any copy is not OK.
- multi_err  out  1  sticky; set on any cycle where all three words are pairwise different.
- dual_fail  out  1  sticky; set when a second copy enters FAILED while another is already FAILED.

Behaviour:
- Classification (combinational on inputs, evaluated when en=1):
  - Copy X disagrees when the other two words are equal and X differs from them.
  - All three equal: clean cycle for every copy.
  - All three pairwise different: triple mismatch; no copy is blamed, multi_err is set, and the cycle counts as neither disagree nor clean for any copy.
- Register timing: all outputs are registered. A state change is visible one cycle after the offending sample.
- Per copy, an 8-bit err_cnt and an 8-bit clean_cnt drive the state machine:
  - OK: a disagree → SUSPECT, err_cnt=1, clean_cnt=0.
  - SUSPECT, disagree: err_cnt+1 and clean_cnt=0. If err_cnt+1 ≥ FAIL_TH → FAILED, and copy_rst_req[X]=1 for exactly one cycle.
  - SUSPECT, clean: clean_cnt+1. If clean_cnt+1 == CLEAN_TH → OK, with err_cnt=0 and clean_cnt=0.
  - FAILED: sticky; counters hold; further disagreements are ignored. Leave only via clear or rst.
- Counter arithmetic: counters saturate at 255 and never wrap.
- dual_fail: if copy X enters FAILED while another copy is already FAILED, dual_fail is set. Two copies entering FAILED on the same cycle also set it.
- Simultaneous events:
  - clear has priority over any comparison that cycle; that cycle's sample is discarded.
  - clear while en=0 still clears.
- Reset (rst=1): copy_state=0, copy_rst_req=0, fault_any=0, multi_err=0, dual_fail=0, all counters 0. Reset mid-SUSPECT or mid-FAILED returns to OK the next cycle.
- en=0 mid-operation: nothing advances and no copy_rst_req pulse is issued; resuming continues from the held counts.

Optional Feature:
- Macro TMR_FAULT_LOG_EN, when defined, adds a fault event log:
  - A free-running 16-bit timestamp counter, cleared by rst, wrapping 0xFFFF→0.
  - A 4-entry FIFO of 18-bit entries {timestamp, id}; id 1/2/3 = A/B/C, id 0 = triple mismatch.
  - Push events: entry to SUSPECT, entry to FAILED, and the first cycle of each triple-mismatch run. At most one push per cycle, priority triple > A > B > C; losing events are dropped and set log_ovf.
  - FIFO full: the event is dropped and log_ovf (sticky) is set.
  - Read side is first-word-fall-through: log_valid out, log_data out [17:0], log_pop in. A pop with log_valid=0 is ignored. Push and pop in the same cycle when full succeed (pop frees the slot).
  - clear empties the FIFO and clears log_ovf.
- Without the macro: these ports are absent and no timestamp or FIFO logic exists.

Test Plan:
- Reset, then en=1 with A=B=C=27'h1234567 for 20 cycles → copy_state=0, all flags 0, copy_rst_req never pulses.
- B differs from A=C for 1 cycle, then clean for 16 cycles → copy_state[3:2]=01 one cycle after the sample; returns to 00 after the 16th clean cycle.
- C differs for 8 consecutive cycles → C FAILED; copy_rst_req=3'b100 for exactly one cycle; fault_any=1. clear → all OK next cycle.
- With C already FAILED, A differs for 8 cycles → A FAILED; dual_fail=1.
- A=1, B=2, C=3 for 3 cycles → multi_err=1, copy_state unchanged. With TMR_FAULT_LOG_EN: exactly one id=0 entry is logged.
- TMR_FAULT_LOG_EN: 5 log events with no pops → 4 entries kept and log_ovf=1; popping returns them in order with increasing timestamps.

Source files
------------

// File: rtl/tmr_fault_monitor.sv
// rtl/tmr_fault_monitor.sv - per-copy TMR health monitor; optional event log under TMR_FAULT_LOG_EN
// Blames the single disagreeing copy each cycle and tracks OK/SUSPECT/FAILED health per copy.
module tmr_fault_monitor #(
   parameter int WIDTH    = 27,
   parameter int FAIL_TH  = 8,
   parameter int CLEAN_TH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clear,
   input  logic [WIDTH-1:0] data_A,
   input  logic [WIDTH-1:0] data_B,
   input  logic [WIDTH-1:0] data_C,
   output logic [5:0]       copy_state,
   output logic [2:0]       copy_rst_req,
   output logic             fault_any,
   output logic             multi_err,
   output logic             dual_fail
`ifdef TMR_FAULT_LOG_EN
   ,
   output logic             log_valid,
   output logic [17:0]      log_data,
   output logic             log_ovf,
   input  logic             log_pop
`endif
);

   localparam logic [1:0] ST_OK      = 2'b00;
   localparam logic [1:0] ST_SUSPECT = 2'b01;
   localparam logic [1:0] ST_FAILED  = 2'b10;
   localparam logic [7:0] FAIL_TH_C  = 8'(FAIL_TH);
   localparam logic [7:0] CLEAN_TH_C = 8'(CLEAN_TH);

   logic [2:0][1:0] state_q, state_d;
   logic [2:0][7:0] err_cnt_q, err_cnt_d;
   logic [2:0][7:0] clean_cnt_q, clean_cnt_d;
   logic [2:0]      rst_req_q, rst_req_d;
   logic            fault_any_q, fault_any_d;
   logic            multi_err_q, multi_err_d;
   logic            dual_fail_q, dual_fail_d;

   logic            eq_ab, eq_bc, eq_ac, all_eq, triple;
   logic [2:0]      disagree, enter_suspect, enter_failed, is_failed;
   logic [7:0]      err_inc, clean_inc;

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   assign eq_ab    = (data_A == data_B);
   assign eq_bc    = (data_B == data_C);
   assign eq_ac    = (data_A == data_C);
   assign all_eq   = eq_ab & eq_bc;
   assign triple   = ~eq_ab & ~eq_bc & ~eq_ac;
   assign disagree = {eq_ab & ~eq_bc, eq_ac & ~eq_ab, eq_bc & ~eq_ab};

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= '0;
         err_cnt_q   <= '0;
         clean_cnt_q <= '0;
         rst_req_q   <= '0;
         fault_any_q <= 1'b0;
         multi_err_q <= 1'b0;
         dual_fail_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         err_cnt_q   <= err_cnt_d;
         clean_cnt_q <= clean_cnt_d;
         rst_req_q   <= rst_req_d;
         fault_any_q <= fault_any_d;
         multi_err_q <= multi_err_d;
         dual_fail_q <= dual_fail_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      err_cnt_d     = err_cnt_q;
      clean_cnt_d   = clean_cnt_q;
      multi_err_d   = multi_err_q;
      dual_fail_d   = dual_fail_q;
      enter_suspect = '0;
      enter_failed  = '0;
      err_inc       = '0;
      clean_inc     = '0;
      if (clear) begin
         state_d     = '0;
         err_cnt_d   = '0;
         clean_cnt_d = '0;
         multi_err_d = 1'b0;
         dual_fail_d = 1'b0;
      end else if (en) begin
         for (int i = 0; i < 3; i++) begin
            err_inc   = sat_inc(err_cnt_q[i]);
            clean_inc = sat_inc(clean_cnt_q[i]);
            case (state_q[i])
               ST_OK: begin
                  if (disagree[i]) begin
                     state_d[i]       = ST_SUSPECT;
                     err_cnt_d[i]     = 8'd1;
                     clean_cnt_d[i]   = 8'd0;
                     enter_suspect[i] = 1'b1;
                  end
               end
               ST_SUSPECT: begin
                  if (disagree[i]) begin
                     err_cnt_d[i]   = err_inc;
                     clean_cnt_d[i] = 8'd0;
                     if (err_inc >= FAIL_TH_C) begin
                        state_d[i]      = ST_FAILED;
                        enter_failed[i] = 1'b1;
                     end
                  end else if (all_eq) begin
                     clean_cnt_d[i] = clean_inc;
                     if (clean_inc == CLEAN_TH_C) begin
                        state_d[i]     = ST_OK;
                        err_cnt_d[i]   = 8'd0;
                        clean_cnt_d[i] = 8'd0;
                     end
                  end
               end
               default: ;
            endcase
         end
         if (triple) begin
            multi_err_d = 1'b1;
         end
      end
      for (int i = 0; i < 3; i++) begin
         is_failed[i] = (state_d[i] == ST_FAILED);
      end
      // FAILED is sticky, so two failed copies after an entry means a second failure
      if ((|enter_failed) &&
          ((is_failed[0] & is_failed[1]) | (is_failed[0] & is_failed[2]) | (is_failed[1] & is_failed[2]))) begin
         dual_fail_d = 1'b1;
      end
      rst_req_d   = enter_failed;
      fault_any_d = |state_d;
   end

`ifdef TMR_FAULT_LOG_EN
   logic [15:0]      ts_q, ts_d;
   logic [3:0][17:0] log_mem_q, log_mem_d;
   logic [1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [2:0]       log_cnt_q, log_cnt_d;
   logic             log_ovf_q, log_ovf_d;
   logic             tri_run_q, tri_run_d;
   logic [3:0]       events;
   logic [1:0]       ev_id;
   logic             push, pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         ts_q      <= '0;
         log_mem_q <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         log_cnt_q <= '0;
         log_ovf_q <= 1'b0;
         tri_run_q <= 1'b0;
      end else begin
         ts_q      <= ts_d;
         log_mem_q <= log_mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         log_cnt_q <= log_cnt_d;
         log_ovf_q <= log_ovf_d;
         tri_run_q <= tri_run_d;
      end
   end

   always_comb begin
      ts_d      = ts_q + 16'd1;
      log_mem_d = log_mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      log_cnt_d = log_cnt_q;
      log_ovf_d = log_ovf_q;
      tri_run_d = tri_run_q;
      events    = '0;
      ev_id     = '0;
      push      = 1'b0;
      pop       = 1'b0;
      if (clear) begin
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         log_cnt_d = '0;
         log_ovf_d = 1'b0;
         tri_run_d = 1'b0;
      end else begin
         if (en) begin
            tri_run_d = triple;
            events    = {enter_suspect | enter_failed, triple & ~tri_run_q};
         end
         if (events[0])      ev_id = 2'd0;
         else if (events[1]) ev_id = 2'd1;
         else if (events[2]) ev_id = 2'd2;
         else                ev_id = 2'd3;
         pop  = log_pop & (log_cnt_q != 3'd0);
         // a same-cycle pop frees the slot, so a full FIFO can still accept
         push = (|events) & ((log_cnt_q != 3'd4) | pop);
         if (((|events) & ~push) | ((events & (events - 4'd1)) != 4'd0)) begin
            log_ovf_d = 1'b1;
         end
         if (push) begin
            log_mem_d[wr_ptr_q] = {ts_q, ev_id};
            wr_ptr_d            = wr_ptr_q + 2'd1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
         end
         log_cnt_d = log_cnt_q + {2'b00, push} - {2'b00, pop};
      end
   end
`endif

   always_comb begin
      copy_state   = state_q;
      copy_rst_req = rst_req_q;
      fault_any    = fault_any_q;
      multi_err    = multi_err_q;
      dual_fail    = dual_fail_q;
`ifdef TMR_FAULT_LOG_EN
      log_valid    = (log_cnt_q != 3'd0);
      log_data     = log_mem_q[rd_ptr_q];
      log_ovf      = log_ovf_q;
`endif
   end

endmodule

// File: tb/tb_tmr_fault_monitor.sv
// tb/tb_tmr_fault_monitor.sv - scoreboard bench for tmr_fault_monitor
module tb_tmr_fault_monitor;
   localparam int W        = 27;
   localparam int FAIL_TH  = 8;
   localparam int CLEAN_TH = 16;
   localparam logic [W-1:0] V = 27'h1234567;

   typedef struct packed {
      logic [5:0] st;
      logic [2:0] rr;
      logic       fa;
      logic       me;
      logic       df;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst, en, clear;
   logic [W-1:0] data_A, data_B, data_C;
   logic [5:0]   copy_state;
   logic [2:0]   copy_rst_req;
   logic         fault_any, multi_err, dual_fail;
   logic         log_valid, log_ovf, log_pop;
   logic [17:0]  log_data;

   exp_t exp_q[$];
   int   m_st[3], m_err[3], m_cln[3];
   bit   m_multi, m_dual;
   int   total = 0;
   int   bad   = 0;
   logic [1:0]  ids[4] = '{2'd1, 2'd2, 2'd3, 2'd0};
   logic [15:0] prev_ts;

   always #5 clk = ~clk;

   tmr_fault_monitor #(.WIDTH(W), .FAIL_TH(FAIL_TH), .CLEAN_TH(CLEAN_TH)) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .clear        (clear),
      .data_A       (data_A),
      .data_B       (data_B),
      .data_C       (data_C),
      .copy_state   (copy_state),
      .copy_rst_req (copy_rst_req),
      .fault_any    (fault_any),
      .multi_err    (multi_err),
      .dual_fail    (dual_fail)
`ifdef TMR_FAULT_LOG_EN
      ,
      .log_valid    (log_valid),
      .log_data     (log_data),
      .log_ovf      (log_ovf),
      .log_pop      (log_pop)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%h want=%h", tag, got, want);
      end
   endtask

   // drive one sample, push the model's prediction, then compare after the edge
   task automatic step(input bit r, input bit e, input bit cl,
                       input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [W-1:0] xc);
      exp_t     ex;
      exp_t     want;
      bit [2:0] dis;
      bit [2:0] entf;
      bit       alleq, tri3;
      int       nf;
      rst = r; en = e; clear = cl;
      data_A = xa; data_B = xb; data_C = xc;
      alleq  = (xa == xb) && (xb == xc);
      tri3   = (xa != xb) && (xb != xc) && (xa != xc);
      dis[0] = (xb == xc) && (xa != xb);
      dis[1] = (xa == xc) && (xb != xa);
      dis[2] = (xa == xb) && (xc != xa);
      entf   = '0;
      if (r || cl) begin
         for (int i = 0; i < 3; i++) begin
            m_st[i] = 0; m_err[i] = 0; m_cln[i] = 0;
         end
         m_multi = 0; m_dual = 0;
      end else if (e) begin
         for (int i = 0; i < 3; i++) begin
            if (m_st[i] == 0 && dis[i]) begin
               m_st[i] = 1; m_err[i] = 1; m_cln[i] = 0;
            end else if (m_st[i] == 1) begin
               if (dis[i]) begin
                  m_err[i] = (m_err[i] < 255) ? m_err[i] + 1 : 255;
                  m_cln[i] = 0;
                  if (m_err[i] >= FAIL_TH) begin
                     m_st[i] = 2; entf[i] = 1'b1;
                  end
               end else if (alleq) begin
                  m_cln[i] = (m_cln[i] < 255) ? m_cln[i] + 1 : 255;
                  if (m_cln[i] == CLEAN_TH) begin
                     m_st[i] = 0; m_err[i] = 0; m_cln[i] = 0;
                  end
               end
            end
         end
         if (tri3) m_multi = 1;
         nf = 0;
         for (int i = 0; i < 3; i++) if (m_st[i] == 2) nf++;
         if (entf != 3'b000 && nf >= 2) m_dual = 1;
      end
      ex.st = {2'(m_st[2]), 2'(m_st[1]), 2'(m_st[0])};
      ex.rr = entf;
      ex.fa = (m_st[0] != 0) || (m_st[1] != 0) || (m_st[2] != 0);
      ex.me = m_multi;
      ex.df = m_dual;
      exp_q.push_back(ex);
      @(posedge clk);
      #1;
      want = exp_q.pop_front();
      check("sb_state", copy_state, want.st);
      check("sb_rst_req", copy_rst_req, want.rr);
      check("sb_fault_any", fault_any, want.fa);
      check("sb_multi_err", multi_err, want.me);
      check("sb_dual_fail", dual_fail, want.df);
   endtask

   task automatic run(input int n, input bit e,
                      input logic [W-1:0] xa, input logic [W-1:0] xb, input logic [W-1:0] xc);
      repeat (n) step(1'b0, e, 1'b0, xa, xb, xc);
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; clear = 1'b0; log_pop = 1'b0;
      data_A = '0; data_B = '0; data_C = '0;
      step(1, 0, 0, V, V, V);
      step(1, 0, 0, V, V, V);
      check("rst_state", copy_state, 6'd0);
      check("rst_flags", {fault_any, multi_err, dual_fail, copy_rst_req}, 6'd0);

      run(20, 1, V, V, V);
      check("clean20_state", copy_state, 6'd0);

      step(0, 1, 0, V, V ^ 27'd1, V);
      check("b_suspect", copy_state, 6'b000100);
      run(15, 1, V, V, V);
      check("b_still_suspect", copy_state, 6'b000100);
      step(0, 1, 0, V, V, V);
      check("b_back_ok", copy_state, 6'b000000);

      run(7, 1, V, V, V ^ 27'd2);
      check("c_suspect7", copy_state, 6'b010000);
      step(0, 1, 0, V, V, V ^ 27'd2);
      check("c_failed", copy_state, 6'b100000);
      check("c_rst_req", copy_rst_req, 3'b100);
      check("c_fault_any", fault_any, 1'b1);
      step(0, 1, 0, V, V, V);
      check("c_rst_req_once", copy_rst_req, 3'b000);
      check("c_sticky", copy_state, 6'b100000);
      step(0, 1, 1, V, V, V ^ 27'd2);
      check("clear_ok", copy_state, 6'd0);
      check("clear_fault_any", fault_any, 1'b0);

      run(8, 1, V, V, V ^ 27'd2);
      check("c_failed2", copy_state, 6'b100000);
      run(7, 1, V ^ 27'd4, V, V);
      check("a_suspect", copy_state, 6'b100001);
      check("no_dual_yet", dual_fail, 1'b0);
      step(0, 1, 0, V ^ 27'd4, V, V);
      check("a_failed", copy_state, 6'b100010);
      check("a_rst_req", copy_rst_req, 3'b001);
      check("dual_fail", dual_fail, 1'b1);

      run(3, 1, 27'd1, 27'd2, 27'd3);
      check("multi_err", multi_err, 1'b1);
      check("triple_state", copy_state, 6'b100010);
      step(0, 1, 1, V, V, V);
      check("clear_flags", {multi_err, dual_fail, fault_any}, 3'b000);

      run(3, 1, V, V ^ 27'd8, V);
      run(10, 0, V, V ^ 27'd8, V);
      check("en0_hold", copy_state, 6'b000100);
      run(4, 1, V, V ^ 27'd8, V);
      check("resume_suspect", copy_state, 6'b000100);
      step(0, 1, 0, V, V ^ 27'd8, V);
      check("resume_failed", copy_state, 6'b001000);
      check("resume_rst_req", copy_rst_req, 3'b010);
      step(0, 0, 1, V, V ^ 27'd8, V);
      check("clear_en0", copy_state, 6'd0);

      run(8, 1, V ^ 27'd16, V, V);
      check("a_failed_again", copy_state, 6'b000010);
      step(1, 1, 0, V ^ 27'd16, V, V);
      check("rst_mid_failed", copy_state, 6'd0);

      for (int k = 0; k < 400; k++) begin
         logic [W-1:0] base;
         int           p;
         bit           e, cl;
         base = W'($urandom);
         p    = $urandom_range(0, 9);
         e    = ($urandom_range(0, 9) != 0);
         cl   = ($urandom_range(0, 49) == 0);
         case (p)
            4, 5:    step(0, e, cl, base ^ 27'd1, base, base);
            6:       step(0, e, cl, base, base ^ 27'd1, base);
            7:       step(0, e, cl, base, base, base ^ 27'd1);
            8:       step(0, e, cl, base, base ^ 27'd1, base ^ 27'd2);
            default: step(0, e, cl, base, base, base);
         endcase
      end

`ifdef TMR_FAULT_LOG_EN
      step(0, 1, 1, V, V, V);
      check("log_empty", log_valid, 1'b0);
      step(0, 1, 0, V ^ 27'd1, V, V);
      step(0, 1, 0, V, V ^ 27'd1, V);
      step(0, 1, 0, V, V, V ^ 27'd1);
      step(0, 1, 0, 27'd1, 27'd2, 27'd3);
      step(0, 1, 0, V, V, V);
      step(0, 1, 0, 27'd1, 27'd2, 27'd3);
      check("log_ovf", log_ovf, 1'b1);
      prev_ts = '0;
      for (int k = 0; k < 4; k++) begin
         check("log_valid", log_valid, 1'b1);
         check("log_id", log_data[1:0], ids[k]);
         if (k > 0) check("log_ts_inc", log_data[17:2] > prev_ts, 1'b1);
         prev_ts = log_data[17:2];
         log_pop = 1'b1;
         step(0, 1, 0, V, V, V);
         log_pop = 1'b0;
      end
      check("log_drained", log_valid, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
